// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, game-state codes, obstacle select
// width and the collision detector state encoding.
package game_pkg;

    localparam int ScreenW = 640;
    localparam int ScreenH = 480;
    localparam int ObsSelW = 4;

    localparam logic [1:0] GS_UNBEGIN = 2'b00;
    localparam logic [1:0] GS_RUNNING = 2'b01;
    localparam logic [1:0] GS_DEAD    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EVAL = 2'd2,
        HIT  = 2'd3
    } det_state_t;

endpackage

// File: rtl/frame_overlap_counter.sv
// Counts pixels where obstacle and dino layers are both opaque inside the
// active area, saturating at 16'hFFFF; flags the last active pixel.
module frame_overlap_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pix_en,
    input  logic [9:0]  i_xx,
    input  logic [8:0]  i_yy,
    input  logic        i_empty_obs,
    input  logic        i_empty_dino,
    input  logic        i_en,
    input  logic        i_clr,
    output logic [15:0] o_count,
    output logic        o_frame_done
);

    localparam logic [9:0] XLim  = 10'(ScreenW);
    localparam logic [8:0] YLim  = 9'(ScreenH);
    localparam logic [9:0] XLast = 10'(ScreenW - 1);
    localparam logic [8:0] YLast = 9'(ScreenH - 1);

    logic        w_qual;
    logic [15:0] r_acc;

    assign w_qual = i_pix_en & ~i_empty_obs & ~i_empty_dino
                  & (i_xx < XLim) & (i_yy < YLim);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= 16'd0;
        end else if (i_en && w_qual && r_acc != 16'hFFFF) begin
            r_acc <= r_acc + 16'd1;
        end
    end

    assign o_count      = r_acc;
    assign o_frame_done = i_pix_en & (i_xx == XLast) & (i_yy == YLast);

endmodule

// File: rtl/obstacle_collision_detect.sv
// Declares a dino/obstacle collision after HitFrames consecutive frames of
// sufficient overlap. Build with COLLISION_GRACE_EN for a post-start grace.
module obstacle_collision_detect
    import game_pkg::*;
#(
    parameter int HitThreshold = 8,
    parameter int HitFrames    = 2
`ifdef COLLISION_GRACE_EN
    ,
    parameter int GraceFrames  = 30
`endif
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [9:0]         xx,
    input  logic [8:0]         yy,
    input  logic [1:0]         gamestate,
    input  logic               isemptyObstacle,
    input  logic               isemptyDino,
    input  logic [ObsSelW-1:0] OBSSEL,
    output logic               collide,
    output logic [ObsSelW-1:0] collide_sel,
    output logic [15:0]        overlap_cnt,
    output logic [3:0]         hit_streak
);

    det_state_t         r_state;
    logic               r_collide;
    logic [ObsSelW-1:0] r_sel;
    logic [15:0]        r_ovl;
    logic [3:0]         r_streak;

    logic        w_running;
    logic        w_grace_on;
    logic [15:0] w_count;
    logic        w_frame_done;
    logic        w_hit;
    logic [3:0]  w_inc;
    logic [3:0]  w_streak_nxt;

    assign w_running = (gamestate == GS_RUNNING);

    frame_overlap_counter u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_pix_en     (pix_en),
        .i_xx         (xx),
        .i_yy         (yy),
        .i_empty_obs  (isemptyObstacle),
        .i_empty_dino (isemptyDino),
        .i_en         ((r_state == SCAN) & w_running),
        .i_clr        (r_state != SCAN),
        .o_count      (w_count),
        .o_frame_done (w_frame_done)
    );

`ifdef COLLISION_GRACE_EN
    logic [5:0] r_grace;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grace <= 6'd0;
        end else if (r_state == IDLE && w_running) begin
            r_grace <= 6'(GraceFrames);
        end else if (r_state == EVAL && r_grace != 6'd0) begin
            r_grace <= r_grace - 6'd1;
        end
    end

    assign w_grace_on = (r_grace != 6'd0);
`else
    assign w_grace_on = 1'b0;
`endif

    assign w_hit = (w_count >= 16'(HitThreshold));
    assign w_inc = (r_streak == 4'hF) ? 4'hF : r_streak + 4'd1;
    assign w_streak_nxt = (w_hit && !w_grace_on) ? w_inc : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_collide <= 1'b0;
            r_sel     <= '0;
            r_ovl     <= 16'd0;
            r_streak  <= 4'd0;
        end else begin
            r_collide <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_streak <= 4'd0;
                    if (w_running) r_state <= SCAN;
                end
                SCAN: begin
                    // game state wins over a simultaneous frame end
                    if (!w_running) begin
                        r_state  <= IDLE;
                        r_streak <= 4'd0;
                    end else if (w_frame_done) begin
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    if (!w_running) begin
                        r_state  <= IDLE;
                        r_streak <= 4'd0;
                    end else begin
                        r_ovl    <= w_count;
                        r_streak <= w_streak_nxt;
                        if (!w_grace_on &&
                            w_streak_nxt >= 4'(HitFrames)) begin
                            r_collide <= 1'b1;
                            r_sel     <= OBSSEL;
                            r_state   <= HIT;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                HIT: begin
                    if (!w_running) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (gamestate == GS_UNBEGIN) r_sel <= '0;
        end
    end

    assign collide     = r_collide;
    assign collide_sel = r_sel;
    assign overlap_cnt = r_ovl;
    assign hit_streak  = r_streak;

endmodule

// File: tb/tb_obstacle_collision_detect.sv
// Directed table-driven bench for obstacle_collision_detect.
// Frames are compressed: overlap pixels, then the frame-end pixel.
module tb_obstacle_collision_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  xx;
    logic [8:0]  yy;
    logic [1:0]  gamestate;
    logic        isemptyObstacle;
    logic        isemptyDino;
    logic [3:0]  OBSSEL;
    logic        collide;
    logic [3:0]  collide_sel;
    logic [15:0] overlap_cnt;
    logic [3:0]  hit_streak;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obstacle_collision_detect #(
        .HitThreshold (8),
        .HitFrames    (2)
`ifdef COLLISION_GRACE_EN
        ,
        .GraceFrames  (3)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pix_en          (pix_en),
        .xx              (xx),
        .yy              (yy),
        .gamestate       (gamestate),
        .isemptyObstacle (isemptyObstacle),
        .isemptyDino     (isemptyDino),
        .OBSSEL          (OBSSEL),
        .collide         (collide),
        .collide_sel     (collide_sel),
        .overlap_cnt     (overlap_cnt),
        .hit_streak      (hit_streak)
    );

    typedef struct {
        int         n_ovl;
        int         n_oob;
        int         n_half;
        bit         fe_ovl;
        logic [3:0] sel;
        logic       e_col;
        logic [3:0] e_streak;
        logic [15:0] e_cnt;
        logic [3:0] e_sel;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic px(input logic [9:0] x, input logic [8:0] y,
                      input logic eo, input logic ed);
        pix_en = 1'b1;
        xx = x;
        yy = y;
        isemptyObstacle = eo;
        isemptyDino = ed;
        tick();
        pix_en = 1'b0;
    endtask

    // Pixels then the frame-end pixel; returns just after the EVAL edge.
    task automatic frame(input int n_ovl, input int n_oob, input int n_half,
                         input bit fe_ovl, input logic [3:0] sel,
                         input logic [1:0] gs_at_end);
        OBSSEL = sel;
        for (int i = 0; i < n_ovl; i++) px(10'd10, 9'd10, 1'b0, 1'b0);
        for (int i = 0; i < n_oob; i++) px(10'd640, 9'd10, 1'b0, 1'b0);
        for (int i = 0; i < n_half; i++) px(10'd20, 9'd20, 1'b0, 1'b1);
        gamestate = gs_at_end;
        px(10'd639, 9'd479, !fe_ovl, !fe_ovl);
        chk("collide_at_frame_end", {15'd0, collide}, 16'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        xx = '0;
        yy = '0;
        gamestate = 2'b00;
        isemptyObstacle = 1'b1;
        isemptyDino = 1'b1;
        OBSSEL = 4'h0;

        tbl[0] = '{10, 0, 0, 1'b0, 4'h5, 1'b0, 4'd1, 16'd10, 4'h0};
        tbl[1] = '{5,  0, 0, 1'b0, 4'h5, 1'b0, 4'd0, 16'd5,  4'h0};
        tbl[2] = '{10, 0, 0, 1'b0, 4'h5, 1'b0, 4'd1, 16'd10, 4'h0};
        tbl[3] = '{5,  0, 0, 1'b0, 4'h5, 1'b0, 4'd0, 16'd5,  4'h0};
        tbl[4] = '{7,  0, 0, 1'b1, 4'h5, 1'b0, 4'd1, 16'd8,  4'h0};
        tbl[5] = '{7,  5, 5, 1'b0, 4'h5, 1'b0, 4'd0, 16'd7,  4'h0};
        tbl[6] = '{10, 0, 0, 1'b0, 4'h5, 1'b0, 4'd1, 16'd10, 4'h0};
        tbl[7] = '{10, 0, 0, 1'b0, 4'h3, 1'b1, 4'd2, 16'd10, 4'h3};

        tick();
        rst = 1'b0;
        chk("rst_collide", {15'd0, collide}, 16'd0);
        chk("rst_sel", {12'd0, collide_sel}, 16'd0);
        chk("rst_ovl", overlap_cnt, 16'd0);
        chk("rst_streak", {12'd0, hit_streak}, 16'd0);

        gamestate = 2'b01;
        tick();

`ifdef COLLISION_GRACE_EN
        for (int f = 1; f <= 5; f++) begin
            frame(20, 0, 0, 1'b0, 4'h6, 2'b01);
            chk("grace_cnt", overlap_cnt, 16'd20);
            chk("grace_col", {15'd0, collide}, (f == 5) ? 16'd1 : 16'd0);
            chk("grace_streak", {12'd0, hit_streak},
                (f <= 3) ? 16'd0 : 16'(f - 3));
            tick();
        end
`else
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].n_ovl, tbl[i].n_oob, tbl[i].n_half,
                  tbl[i].fe_ovl, tbl[i].sel, 2'b01);
            chk($sformatf("t%0d_col", i), {15'd0, collide},
                {15'd0, tbl[i].e_col});
            chk($sformatf("t%0d_streak", i), {12'd0, hit_streak},
                {12'd0, tbl[i].e_streak});
            chk($sformatf("t%0d_cnt", i), overlap_cnt, tbl[i].e_cnt);
            chk($sformatf("t%0d_sel", i), {12'd0, collide_sel},
                {12'd0, tbl[i].e_sel});
            tick();
            chk($sformatf("t%0d_col_after", i), {15'd0, collide}, 16'd0);
        end

        // In HIT nothing is counted and results are held
        frame(20, 0, 0, 1'b0, 4'h9, 2'b01);
        chk("hit_col", {15'd0, collide}, 16'd0);
        chk("hit_cnt_held", overlap_cnt, 16'd10);
        chk("hit_sel_held", {12'd0, collide_sel}, 16'd3);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_collide", {15'd0, collide}, 16'd0);
        chk("rst2_sel", {12'd0, collide_sel}, 16'd0);
        chk("rst2_ovl", overlap_cnt, 16'd0);
        chk("rst2_streak", {12'd0, hit_streak}, 16'd0);

        // Dead on the frame-end clock with streak at 1
        tick();
        frame(10, 0, 0, 1'b0, 4'h2, 2'b01);
        chk("pre_dead_streak", {12'd0, hit_streak}, 16'd1);
        tick();
        frame(10, 0, 0, 1'b0, 4'h2, 2'b10);
        chk("dead_col", {15'd0, collide}, 16'd0);
        chk("dead_streak", {12'd0, hit_streak}, 16'd0);
        chk("dead_cnt_held", overlap_cnt, 16'd10);
        tick();
        chk("dead_col2", {15'd0, collide}, 16'd0);

        gamestate = 2'b01;
        tick();
        frame(10, 0, 0, 1'b0, 4'h4, 2'b01);
        chk("restart_streak", {12'd0, hit_streak}, 16'd1);
        chk("restart_col", {15'd0, collide}, 16'd0);
        tick();
        frame(9, 0, 0, 1'b0, 4'hA, 2'b01);
        chk("restart_hit", {15'd0, collide}, 16'd1);
        chk("restart_sel", {12'd0, collide_sel}, 16'hA);
        chk("restart_cnt", overlap_cnt, 16'd9);

        // UnBegin from HIT clears the captured select
        gamestate = 2'b00;
        tick();
        tick();
        chk("unbegin_sel", {12'd0, collide_sel}, 16'd0);
        chk("unbegin_cnt", overlap_cnt, 16'd9);

        gamestate = 2'b01;
        tick();
        frame(70000, 0, 0, 1'b1, 4'h1, 2'b01);
        chk("sat_cnt", overlap_cnt, 16'hFFFF);
        chk("sat_streak", {12'd0, hit_streak}, 16'd1);
        chk("sat_col", {15'd0, collide}, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
